// File: rtl/el2_ifu_iccm_arb_ctl.sv
// ICCM port arbiter: shares the memory among fetch, DMA and the single-bit ECC
// correction writeback, and tags each read return with its requester.
module el2_ifu_iccm_arb_ctl #(
   parameter int ICCM_BITS        = 16,
   parameter int FETCH_STARVE_MAX = 4
) (
   input  logic                 clk,
   input  logic                 rst_l,
   input  logic                 ifc_req,
   input  logic [ICCM_BITS-1:1] ifc_addr,
   output logic                 ifc_gnt,
   input  logic                 dma_req,
   input  logic                 dma_wr,
   input  logic [ICCM_BITS-1:1] dma_addr,
   input  logic [2:0]           dma_size,
   input  logic [77:0]          dma_wdata,
   output logic                 dma_gnt,
   input  logic                 ecc_err_valid,
   input  logic [ICCM_BITS-1:1] ecc_err_addr,
   input  logic [38:0]          ecc_corr_data,
   output logic                 iccm_wren,
   output logic                 iccm_rden,
   output logic [ICCM_BITS-1:1] iccm_rw_addr,
   output logic [2:0]           iccm_wr_size,
   output logic [77:0]          iccm_wr_data,
   output logic                 iccm_buf_correct_ecc,
   output logic                 iccm_correction_state,
   output logic                 ifc_rd_vld,
   output logic                 dma_rd_vld,
   output logic                 corr_drop
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      CORR_WAIT = 2'd1,
      CORR_WR   = 2'd2
   } state_e;

   localparam logic [3:0] STARVE_MAX = 4'(FETCH_STARVE_MAX);

   state_e               state_q, state_d;
   logic [3:0]           starve_q, starve_d;
   logic [ICCM_BITS-1:1] corrAddr_q;
   logic [38:0]          corrData_q;
   logic                 ifcRdVld_q, dmaRdVld_q;
   logic                 fetchForced;

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:      if (ecc_err_valid) state_d = CORR_WAIT;
         CORR_WAIT: state_d = CORR_WR;
         CORR_WR:   state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // Grants are gated by rst_l so every output reads 0 while reset is held.
   always_comb begin
      fetchForced           = (starve_q == STARVE_MAX);
      ifc_gnt               = 1'b0;
      dma_gnt               = 1'b0;
      iccm_wren             = 1'b0;
      iccm_rden             = 1'b0;
      iccm_rw_addr          = '0;
      iccm_wr_size          = 3'b000;
      iccm_wr_data          = '0;
      iccm_buf_correct_ecc  = 1'b0;
      iccm_correction_state = (state_q != IDLE);
      corr_drop             = ecc_err_valid && (state_q != IDLE);
      if (state_q == IDLE && rst_l) begin
         dma_gnt = dma_req && (!ifc_req || !fetchForced);
         ifc_gnt = ifc_req && (!dma_req || fetchForced);
      end
      if (state_q == CORR_WR) begin
         iccm_wren            = 1'b1;
         iccm_buf_correct_ecc = 1'b1;
         iccm_rw_addr         = corrAddr_q;
         iccm_wr_size         = 3'b010;
         iccm_wr_data         = {corrData_q, corrData_q};
      end else if (ifc_gnt) begin
         iccm_rden    = 1'b1;
         iccm_rw_addr = ifc_addr;
      end else if (dma_gnt) begin
         iccm_rw_addr = dma_addr;
         if (dma_wr) begin
            iccm_wren    = 1'b1;
            iccm_wr_size = dma_size;
            iccm_wr_data = dma_wdata;
         end else begin
            iccm_rden = 1'b1;
         end
      end
   end

   // Starvation count holds while a correction blocks both requesters.
   always_comb begin
      starve_d = starve_q;
      if (dma_gnt && ifc_req) begin
         if (starve_q != STARVE_MAX) starve_d = starve_q + 4'd1;
      end else if (ifc_gnt || !ifc_req) begin
         starve_d = 4'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         starve_q   <= 4'd0;
         corrAddr_q <= '0;
         corrData_q <= '0;
         ifcRdVld_q <= 1'b0;
         dmaRdVld_q <= 1'b0;
      end else begin
         starve_q   <= starve_d;
         ifcRdVld_q <= ifc_gnt;
         dmaRdVld_q <= dma_gnt && !dma_wr;
         if (state_q == IDLE && ecc_err_valid) begin
            corrAddr_q <= ecc_err_addr;
            corrData_q <= ecc_corr_data;
         end
      end
   end

   assign ifc_rd_vld = ifcRdVld_q;
   assign dma_rd_vld = dmaRdVld_q;

endmodule

// File: tb/tb_el2_ifu_iccm_arb_ctl.sv
// Directed, table-driven bench for the ICCM arbiter: per-cycle input/expected
// records plus hand sequences for correction overlap and mid-correction reset.
module tb_el2_ifu_iccm_arb_ctl;

   typedef struct packed {
      logic        ifcReq;
      logic [14:0] ifcAddr;
      logic        dmaReq;
      logic        dmaWr;
      logic [14:0] dmaAddr;
      logic [2:0]  dmaSize;
      logic [77:0] dmaWdata;
      logic        eccValid;
      logic [14:0] eccAddr;
      logic [38:0] eccData;
   } ins_t;

   typedef struct packed {
      logic        ifcGnt;
      logic        dmaGnt;
      logic        wren;
      logic        rden;
      logic [14:0] addr;
      logic [2:0]  size;
      logic [77:0] wdata;
      logic        bufCorr;
      logic        corrState;
      logic        ifcRdVld;
      logic        dmaRdVld;
      logic        corrDrop;
   } outs_t;

   typedef struct {
      string name;
      ins_t  in;
      outs_t exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_l = 1'b0;
   logic        ifc_req = 1'b0;
   logic [15:1] ifc_addr = '0;
   logic        ifc_gnt;
   logic        dma_req = 1'b0;
   logic        dma_wr = 1'b0;
   logic [15:1] dma_addr = '0;
   logic [2:0]  dma_size = '0;
   logic [77:0] dma_wdata = '0;
   logic        dma_gnt;
   logic        ecc_err_valid = 1'b0;
   logic [15:1] ecc_err_addr = '0;
   logic [38:0] ecc_corr_data = '0;
   logic        iccm_wren, iccm_rden;
   logic [15:1] iccm_rw_addr;
   logic [2:0]  iccm_wr_size;
   logic [77:0] iccm_wr_data;
   logic        iccm_buf_correct_ecc, iccm_correction_state;
   logic        ifc_rd_vld, dma_rd_vld, corr_drop;

   int testsRun = 0;
   int testsFailed = 0;
   vec_t vecs[$];
   outs_t act;

   localparam logic [77:0] DMA_DATA  = 78'h3A51_2345_6789_ABCD_EF01;
   localparam logic [77:0] DMA_DATA2 = 78'h0123_4567_89AB_CDEF_5555;
   localparam logic [38:0] CORR_DATA = 39'h12_3456_789A;
   localparam logic [38:0] CORR_DATA2 = 39'h7F_0000_0001;

   el2_ifu_iccm_arb_ctl #(.ICCM_BITS(16), .FETCH_STARVE_MAX(4)) dut (
      .clk(clk), .rst_l(rst_l),
      .ifc_req(ifc_req), .ifc_addr(ifc_addr), .ifc_gnt(ifc_gnt),
      .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr),
      .dma_size(dma_size), .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
      .ecc_err_valid(ecc_err_valid), .ecc_err_addr(ecc_err_addr),
      .ecc_corr_data(ecc_corr_data),
      .iccm_wren(iccm_wren), .iccm_rden(iccm_rden), .iccm_rw_addr(iccm_rw_addr),
      .iccm_wr_size(iccm_wr_size), .iccm_wr_data(iccm_wr_data),
      .iccm_buf_correct_ecc(iccm_buf_correct_ecc),
      .iccm_correction_state(iccm_correction_state),
      .ifc_rd_vld(ifc_rd_vld), .dma_rd_vld(dma_rd_vld), .corr_drop(corr_drop)
   );

   // Free-running 10-unit clock; inputs change 1 after posedge, checks at negedge.
   always #5 clk = ~clk;

   // Gathers every DUT output into one record for whole-cycle comparison.
   always_comb begin
      act = '{ifcGnt: ifc_gnt, dmaGnt: dma_gnt, wren: iccm_wren, rden: iccm_rden,
              addr: iccm_rw_addr, size: iccm_wr_size, wdata: iccm_wr_data,
              bufCorr: iccm_buf_correct_ecc, corrState: iccm_correction_state,
              ifcRdVld: ifc_rd_vld, dmaRdVld: dma_rd_vld, corrDrop: corr_drop};
   end

   function automatic ins_t inNone();
      return '0;
   endfunction

   function automatic ins_t inFetch(input logic [14:0] a);
      ins_t r = '0;
      r.ifcReq = 1'b1;
      r.ifcAddr = a;
      return r;
   endfunction

   function automatic ins_t inDma(input logic wr, input logic [14:0] a,
                                  input logic [2:0] sz, input logic [77:0] d);
      ins_t r = '0;
      r.dmaReq = 1'b1;
      r.dmaWr = wr;
      r.dmaAddr = a;
      r.dmaSize = sz;
      r.dmaWdata = d;
      return r;
   endfunction

   function automatic ins_t addFetch(input ins_t r, input logic [14:0] a);
      ins_t o = r;
      o.ifcReq = 1'b1;
      o.ifcAddr = a;
      return o;
   endfunction

   function automatic ins_t addErr(input ins_t r, input logic [14:0] a, input logic [38:0] d);
      ins_t o = r;
      o.eccValid = 1'b1;
      o.eccAddr = a;
      o.eccData = d;
      return o;
   endfunction

   function automatic outs_t outF(input logic [14:0] a);
      outs_t r = '0;
      r.ifcGnt = 1'b1;
      r.rden = 1'b1;
      r.addr = a;
      return r;
   endfunction

   function automatic outs_t outDRd(input logic [14:0] a);
      outs_t r = '0;
      r.dmaGnt = 1'b1;
      r.rden = 1'b1;
      r.addr = a;
      return r;
   endfunction

   function automatic outs_t outDWr(input logic [14:0] a, input logic [2:0] sz,
                                    input logic [77:0] d);
      outs_t r = '0;
      r.dmaGnt = 1'b1;
      r.wren = 1'b1;
      r.addr = a;
      r.size = sz;
      r.wdata = d;
      return r;
   endfunction

   function automatic outs_t vld(input outs_t o, input logic iv, input logic dv);
      outs_t r = o;
      r.ifcRdVld = iv;
      r.dmaRdVld = dv;
      return r;
   endfunction

   function automatic outs_t outCorrWr(input logic [14:0] a, input logic [38:0] d);
      outs_t r = '0;
      r.wren = 1'b1;
      r.bufCorr = 1'b1;
      r.corrState = 1'b1;
      r.addr = a;
      r.size = 3'b010;
      r.wdata = {d, d};
      return r;
   endfunction

   task automatic addVec(input string n, input ins_t i, input outs_t e);
      vec_t v;
      v.name = n;
      v.in = i;
      v.exp = e;
      vecs.push_back(v);
   endtask

   task automatic applyStimulus(input ins_t i);
      ifc_req = i.ifcReq;
      ifc_addr = i.ifcAddr;
      dma_req = i.dmaReq;
      dma_wr = i.dmaWr;
      dma_addr = i.dmaAddr;
      dma_size = i.dmaSize;
      dma_wdata = i.dmaWdata;
      ecc_err_valid = i.eccValid;
      ecc_err_addr = i.eccAddr;
      ecc_corr_data = i.eccData;
   endtask

   task automatic compareNow(input string n, input outs_t e);
      testsRun++;
      if (act !== e) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h required %h", n, act, e);
      end
   endtask

   task automatic checkOutput(input string n, input outs_t e);
      @(negedge clk);
      compareNow(n, e);
      @(posedge clk);
      #1;
   endtask

   task automatic step(input string n, input ins_t i, input outs_t e);
      applyStimulus(i);
      checkOutput(n, e);
   endtask

   initial begin
      outs_t e;
      ins_t  both;

      // Basic single-requester traffic.
      addVec("idle0",      inNone(),                          '0);
      addVec("fetch40",    inFetch(15'h0040),                 outF(15'h0040));
      addVec("fetchVld",   inNone(),                          vld('0, 1'b1, 1'b0));
      addVec("dmaWrDw",    inDma(1'b1, 15'h0100, 3'b011, DMA_DATA),
                           outDWr(15'h0100, 3'b011, DMA_DATA));
      addVec("dmaWrNoVld", inNone(),                          '0);
      addVec("dmaRd",      inDma(1'b0, 15'h0123, 3'b010, '0), outDRd(15'h0123));
      addVec("dmaRdVld",   inNone(),                          vld('0, 1'b0, 1'b1));

      // Both requesting continuously: D,D,D,D,F twice.
      both = addFetch(inDma(1'b0, 15'h0200, 3'b010, '0), 15'h0040);
      for (int k = 0; k < 10; k++) begin
         logic prevF, prevD;
         prevF = (k > 0) && ((k - 1) % 5 == 4);
         prevD = (k > 0) && !prevF;
         e = (k % 5 == 4) ? outF(15'h0040) : outDRd(15'h0200);
         addVec($sformatf("starve%0d", k), both, vld(e, prevF, prevD));
      end
      addVec("starveTail", inNone(), vld('0, 1'b1, 1'b0));

      // Dropping ifc_req for one cycle clears the starvation count.
      both = addFetch(inDma(1'b1, 15'h0300, 3'b010, DMA_DATA2), 15'h0040);
      addVec("clr0", both, outDWr(15'h0300, 3'b010, DMA_DATA2));
      addVec("clrDmaOnly", inDma(1'b1, 15'h0300, 3'b010, DMA_DATA2),
             outDWr(15'h0300, 3'b010, DMA_DATA2));
      for (int k = 0; k < 4; k++)
         addVec($sformatf("clrD%0d", k), both, outDWr(15'h0300, 3'b010, DMA_DATA2));
      addVec("clrF", both, outF(15'h0040));
      addVec("clrTail", inNone(), vld('0, 1'b1, 1'b0));

      // Reset state with all requests idle.
      applyStimulus(inNone());
      #2;
      compareNow("reset", '0);
      @(negedge clk);
      #1 rst_l = 1'b1;
      @(posedge clk);
      #1;

      foreach (vecs[i]) step(vecs[i].name, vecs[i].in, vecs[i].exp);

      // Correction with an overlapping report that must be dropped.
      step("errN", addErr(inFetch(15'h0040), 15'h0208, CORR_DATA), outF(15'h0040));
      e = vld('0, 1'b1, 1'b0);
      e.corrState = 1'b1;
      e.corrDrop = 1'b1;
      step("errN1Drop", addErr(inFetch(15'h0040), 15'h07FF, 39'h55_5555_5555), e);
      step("errN2Wr", inFetch(15'h0040), outCorrWr(15'h0208, CORR_DATA));

      // A fresh report in the resume cycle is accepted.
      step("errN3Accept", addErr(inFetch(15'h0040), 15'h0010, CORR_DATA2), outF(15'h0040));
      e = vld('0, 1'b1, 1'b0);
      e.corrState = 1'b1;
      step("err2Wait", inFetch(15'h0040), e);
      step("err2Wr", inFetch(15'h0040), outCorrWr(15'h0010, CORR_DATA2));
      step("err2Resume", inFetch(15'h0040), outF(15'h0040));

      // Reset during CORR_WAIT loses the pending write.
      step("rstErr", addErr(inNone(), 15'h0300, 39'h01_0203_0405), vld('0, 1'b1, 1'b0));
      applyStimulus(inNone());
      @(negedge clk);
      e = '0;
      e.corrState = 1'b1;
      compareNow("rstWait", e);
      #1 rst_l = 1'b0;
      #1 compareNow("rstAsync", '0);
      @(posedge clk);
      #1 rst_l = 1'b1;
      step("rstNoWr0", inNone(), '0);
      step("rstNoWr1", inNone(), '0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
